// File: rtl/spi_reg_frame_ctrl.sv
// spi_reg_frame_ctrl
// Frame-level register-access controller in the SPI clock domain. Each
// chip-select frame is a command byte followed by a burst of data bytes.
// Command bit 7 selects read (1) or write (0) and bits 6:0 give the start
// address. Writes commit one strobe per data byte. Reads insert one dummy
// turnaround byte, then fetch one register per byte onto MISO. MISO sends
// STATUS_BYTE during the command byte.
module spi_reg_frame_ctrl #(
    parameter bit         AUTO_INC    = 1'b1,
    parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
    input  logic       w_SPI_Clk,
    input  logic       i_Rst_L,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO_Bit,
    output logic [6:0] o_Reg_Addr,
    output logic       o_Reg_Wr_En,
    output logic [7:0] o_Reg_Wr_Data,
    output logic       o_Reg_Rd_En,
    input  logic [7:0] i_Reg_Rd_Data,
    output logic [1:0] o_State,
    output logic [7:0] o_Byte_Count,
    output logic       o_Addr_Wrap
);

    typedef enum logic [1:0] {
        ST_CMD     = 2'b00,
        ST_WR      = 2'b01,
        ST_RD_WAIT = 2'b10,
        ST_RD      = 2'b11
    } state_t;

    state_t     r_State;
    logic [2:0] r_Bit_Cnt;
    logic [6:0] r_Rx_Shift;
    logic [6:0] r_Addr;
    logic [7:0] r_Tx_Shift;
    logic [7:0] r_Byte_Count;
    logic       r_Addr_Wrap;

    logic       w_Frame_Clr_L;
    logic       w_Byte_Done;
    logic [7:0] w_Byte;
    logic       w_Addr_Step;
    logic [6:0] w_Addr_Next;
    logic       w_Wrap_Step;
    logic [7:0] w_Tx_Reload;

    // Frame state is cleared either by the global reset or by chip select
    // going high. Both are asynchronous, so they merge into one active-low clear.
    assign w_Frame_Clr_L = i_Rst_L & ~i_SPI_CS_n;

    // Byte-boundary decode: strobes, write data, next address and MISO reload.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        w_Byte        = {r_Rx_Shift, i_SPI_MOSI};
        w_Byte_Done   = 1'b0;
        o_Reg_Wr_En   = 1'b0;
        o_Reg_Rd_En   = 1'b0;
        o_Reg_Wr_Data = 8'h00;
        w_Addr_Step   = 1'b0;
        w_Addr_Next   = r_Addr;
        w_Wrap_Step   = 1'b0;
        w_Tx_Reload   = 8'h00;

        // The 8th edge of a byte is the one sampled while bit_cnt is 7.
        w_Byte_Done   = ~i_SPI_CS_n && (r_Bit_Cnt == 3'd7);
        o_Reg_Wr_En   = w_Byte_Done && (r_State == ST_WR);
        o_Reg_Rd_En   = w_Byte_Done && ((r_State == ST_RD_WAIT) || (r_State == ST_RD));
        // Write data is forced to zero outside the strobe, so reset and idle states show zero.
        o_Reg_Wr_Data = o_Reg_Wr_En ? w_Byte : 8'h00;

        w_Addr_Step   = o_Reg_Wr_En || o_Reg_Rd_En;
        if (AUTO_INC) begin
            w_Addr_Next = r_Addr + 7'd1;
            w_Wrap_Step = w_Addr_Step && (r_Addr == 7'h7F);
        end

        // Read states reload the fetched register. Command and write states reload zeros.
        w_Tx_Reload   = o_Reg_Rd_En ? i_Reg_Rd_Data : 8'h00;
    end

    // Frame FSM: bit framing, command decode, address tracking, byte count and MISO shifter.
    always_ff @(posedge w_SPI_Clk or negedge w_Frame_Clr_L) begin
        // NOTE: sequential state uses non-blocking assignments, so every branch reads pre-edge values.
        if (!w_Frame_Clr_L) begin
            r_State      <= ST_CMD;
            r_Bit_Cnt    <= 3'd0;
            r_Rx_Shift   <= 7'd0;
            r_Addr       <= 7'd0;
            r_Tx_Shift   <= STATUS_BYTE;
            r_Byte_Count <= 8'd0;
        end else begin
            r_Rx_Shift <= w_Byte[6:0];
            r_Bit_Cnt  <= r_Bit_Cnt + 3'd1;
            r_Tx_Shift <= {r_Tx_Shift[6:0], 1'b0};

            if (w_Byte_Done) begin
                r_Tx_Shift <= w_Tx_Reload;
                if (r_Byte_Count != 8'hFF) begin
                    r_Byte_Count <= r_Byte_Count + 8'd1;
                end

                case (r_State)
                    ST_CMD: begin
                        r_Addr  <= w_Byte[6:0];
                        r_State <= w_Byte[7] ? ST_RD_WAIT : ST_WR;
                    end
                    ST_WR: begin
                        r_Addr <= w_Addr_Next;
                    end
                    ST_RD_WAIT: begin
                        r_Addr  <= w_Addr_Next;
                        r_State <= ST_RD;
                    end
                    ST_RD: begin
                        r_Addr <= w_Addr_Next;
                    end
                    default: begin
                        r_State <= ST_CMD;
                    end
                endcase
            end
        end
    end

    // Sticky wrap flag: it survives chip-select toggles and only the global reset clears it.
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Addr_Wrap <= 1'b0;
        end else if (w_Wrap_Step) begin
            r_Addr_Wrap <= 1'b1;
        end
    end

    assign o_SPI_MISO_Bit = r_Tx_Shift[7];
    assign o_Reg_Addr     = r_Addr;
    assign o_State        = r_State;
    assign o_Byte_Count   = r_Byte_Count;
    assign o_Addr_Wrap    = r_Addr_Wrap;

endmodule

// File: tb/tb_spi_reg_frame_ctrl.sv
// tb_spi_reg_frame_ctrl
// Directed bench for spi_reg_frame_ctrl. The bench acts as the SPI master and
// as the register bank. Inputs change 1 time unit after a rising edge. Outputs
// are sampled on the falling edge.
// dut0 uses AUTO_INC=1. dut1 uses AUTO_INC=0.
module tb_spi_reg_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_l;
    logic       cs0_n;
    logic       cs1_n;
    logic       mosi;
    logic       sel;
    logic [7:0] mem [128];

    logic       miso0, wr0, rd0, wrap0;
    logic [6:0] addr0;
    logic [7:0] wdata0, rdata0, cnt0;
    logic [1:0] state0;
    logic       miso1, wr1, rd1, wrap1;
    logic [6:0] addr1;
    logic [7:0] wdata1, rdata1, cnt1;
    logic [1:0] state1;

    assign rdata0 = mem[addr0];
    assign rdata1 = mem[addr1];

    spi_reg_frame_ctrl #(.AUTO_INC(1'b1), .STATUS_BYTE(8'hA5)) dut0 (
        .w_SPI_Clk(clk), .i_Rst_L(rst_l), .i_SPI_CS_n(cs0_n), .i_SPI_MOSI(mosi),
        .o_SPI_MISO_Bit(miso0), .o_Reg_Addr(addr0), .o_Reg_Wr_En(wr0),
        .o_Reg_Wr_Data(wdata0), .o_Reg_Rd_En(rd0), .i_Reg_Rd_Data(rdata0),
        .o_State(state0), .o_Byte_Count(cnt0), .o_Addr_Wrap(wrap0)
    );

    spi_reg_frame_ctrl #(.AUTO_INC(1'b0), .STATUS_BYTE(8'hA5)) dut1 (
        .w_SPI_Clk(clk), .i_Rst_L(rst_l), .i_SPI_CS_n(cs1_n), .i_SPI_MOSI(mosi),
        .o_SPI_MISO_Bit(miso1), .o_Reg_Addr(addr1), .o_Reg_Wr_En(wr1),
        .o_Reg_Wr_Data(wdata1), .o_Reg_Rd_En(rd1), .i_Reg_Rd_Data(rdata1),
        .o_State(state1), .o_Byte_Count(cnt1), .o_Addr_Wrap(wrap1)
    );

    // Outputs of the currently selected instance.
    logic       m_miso, m_wr, m_rd, m_wrap;
    logic [6:0] m_addr;
    logic [7:0] m_wdata, m_cnt;
    logic [1:0] m_state;
    assign m_miso  = sel ? miso1  : miso0;
    assign m_wr    = sel ? wr1    : wr0;
    assign m_rd    = sel ? rd1    : rd0;
    assign m_wrap  = sel ? wrap1  : wrap0;
    assign m_addr  = sel ? addr1  : addr0;
    assign m_wdata = sel ? wdata1 : wdata0;
    assign m_cnt   = sel ? cnt1   : cnt0;
    assign m_state = sel ? state1 : state0;

    int n_checks = 0;
    int n_errors = 0;

    // Per-byte frame record: bytes sent, MISO bytes seen, and the strobes in the bit-7 period.
    logic [7:0]  f_tx    [300];
    logic [7:0]  f_rx    [300];
    logic        f_wr    [300];
    logic        f_rd    [300];
    logic [6:0]  f_addr  [300];
    logic [7:0]  f_data  [300];
    logic        f_early [300];
    logic [25:0] f_exp   [300];

    function automatic logic [25:0] exp_byte(input logic [7:0] mi, input logic wr, input logic rd,
                                             input logic [6:0] ad, input logic [7:0] dt);
        return {mi, wr, rd, ad, dt, 1'b0};
    endfunction

    function automatic logic [25:0] pack_obs(input int j);
        return {f_rx[j], f_wr[j], f_rd[j], f_addr[j], f_data[j], f_early[j]};
    endfunction

    // Shift one byte. Called 1 unit after a rising edge, and returns at the same phase.
    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx, output logic wr,
                             output logic rd, output logic [6:0] ad, output logic [7:0] dt,
                             output logic early);
        rx = 8'h00; wr = 1'b0; rd = 1'b0; ad = 7'h00; dt = 8'h00; early = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            @(negedge clk);
            rx[i] = m_miso;
            if (i == 0) begin
                wr = m_wr; rd = m_rd; ad = m_addr; dt = m_wdata;
                if (m_wr) mem[m_addr] = m_wdata;
            end else if (m_wr || m_rd) begin
                early = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_bytes(input int first, input int n);
        logic [7:0] rx, dt;
        logic [6:0] ad;
        logic       wr, rd, early;
        for (int j = first; j < first + n; j++) begin
            xfer_byte(f_tx[j], rx, wr, rd, ad, dt, early);
            f_rx[j] = rx; f_wr[j] = wr; f_rd[j] = rd;
            f_addr[j] = ad; f_data[j] = dt; f_early[j] = early;
        end
    endtask

    task automatic cs_low();
        @(posedge clk);
        #1;
        if (sel) cs1_n = 1'b0;
        else     cs0_n = 1'b0;
    endtask

    task automatic end_frame();
        cs0_n = 1'b1;
        cs1_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_l = 1'b0; cs0_n = 1'b1; cs1_n = 1'b1; mosi = 1'b1; sel = 1'b0;
        #12;
        n_checks++;
        if ({state0, cnt0, addr0, wr0, rd0, wdata0, wrap0, miso0} !== {2'b00, 8'h00, 7'h00, 4'b0000, 8'h00, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_dut0 got st=%b cnt=%h addr=%h wr=%b rd=%b wd=%h wrap=%b miso=%b exp 00/00/00/0/0/00/0/1",
                     state0, cnt0, addr0, wr0, rd0, wdata0, wrap0, miso0);
        end
        n_checks++;
        if ({state1, cnt1, addr1, wr1, rd1, wdata1, wrap1, miso1} !== {2'b00, 8'h00, 7'h00, 4'b0000, 8'h00, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_dut1 got st=%b cnt=%h addr=%h miso=%b exp st=00 cnt=00 addr=00 miso=1",
                     state1, cnt1, addr1, miso1);
        end
        // Reset dominates clock edges even with chip select low.
        cs0_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if ({state0, cnt0, wr0, miso0} !== {2'b00, 8'h00, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_hold got st=%b cnt=%h wr=%b miso=%b exp 00/00/0/1", state0, cnt0, wr0, miso0);
        end
        cs0_n = 1'b1;
        #2;
        rst_l = 1'b1;
    endtask

    task automatic test_write_burst();
        sel = 1'b0;
        f_tx[0] = 8'h05; f_tx[1] = 8'h11; f_tx[2] = 8'h22;
        f_exp[0] = exp_byte(8'hA5, 1'b0, 1'b0, 7'h00, 8'h00);
        f_exp[1] = exp_byte(8'h00, 1'b1, 1'b0, 7'h05, 8'h11);
        f_exp[2] = exp_byte(8'h00, 1'b1, 1'b0, 7'h06, 8'h22);
        cs_low();
        run_bytes(0, 3);
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (pack_obs(j) !== f_exp[j]) begin
                n_errors++;
                $display("FAIL wr_burst byte%0d got %h exp %h (miso,wr,rd,addr,data,early)", j, pack_obs(j), f_exp[j]);
            end
        end
        n_checks++;
        if ({m_state, m_cnt} !== {2'b01, 8'd3}) begin
            n_errors++;
            $display("FAIL wr_burst_count got st=%b cnt=%0d exp st=01 cnt=3", m_state, m_cnt);
        end
        cs0_n = 1'b1;
        #1;
        n_checks++;
        if ({m_state, m_cnt, m_addr, m_miso} !== {2'b00, 8'd0, 7'h00, 1'b1}) begin
            n_errors++;
            $display("FAIL wr_burst_cs_clear got st=%b cnt=%0d addr=%h miso=%b exp 00/0/00/1", m_state, m_cnt, m_addr, m_miso);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_burst();
        sel = 1'b0;
        mem[3] = 8'h3C; mem[4] = 8'hC3; mem[5] = 8'h5A;
        f_tx[0] = 8'h83; f_tx[1] = 8'h00; f_tx[2] = 8'h00; f_tx[3] = 8'h00;
        f_exp[0] = exp_byte(8'hA5, 1'b0, 1'b0, 7'h00, 8'h00);
        f_exp[1] = exp_byte(8'h00, 1'b0, 1'b1, 7'h03, 8'h00);
        f_exp[2] = exp_byte(8'h3C, 1'b0, 1'b1, 7'h04, 8'h00);
        f_exp[3] = exp_byte(8'hC3, 1'b0, 1'b1, 7'h05, 8'h00);
        cs_low();
        run_bytes(0, 4);
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (pack_obs(j) !== f_exp[j]) begin
                n_errors++;
                $display("FAIL rd_burst byte%0d got %h exp %h (miso,wr,rd,addr,data,early)", j, pack_obs(j), f_exp[j]);
            end
        end
        n_checks++;
        if ({m_state, m_cnt, m_addr} !== {2'b11, 8'd4, 7'h06}) begin
            n_errors++;
            $display("FAIL rd_burst_state got st=%b cnt=%0d addr=%h exp st=11 cnt=4 addr=06", m_state, m_cnt, m_addr);
        end
        end_frame();
    endtask

    task automatic test_wrap();
        sel = 1'b0;
        n_checks++;
        if (m_wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_pre got %b exp 0", m_wrap);
        end
        f_tx[0] = 8'h7F; f_tx[1] = 8'hAA; f_tx[2] = 8'hBB;
        f_exp[0] = exp_byte(8'hA5, 1'b0, 1'b0, 7'h00, 8'h00);
        f_exp[1] = exp_byte(8'h00, 1'b1, 1'b0, 7'h7F, 8'hAA);
        f_exp[2] = exp_byte(8'h00, 1'b1, 1'b0, 7'h00, 8'hBB);
        cs_low();
        run_bytes(0, 3);
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (pack_obs(j) !== f_exp[j]) begin
                n_errors++;
                $display("FAIL wrap byte%0d got %h exp %h (miso,wr,rd,addr,data,early)", j, pack_obs(j), f_exp[j]);
            end
        end
        n_checks++;
        if (m_wrap !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_set got %b exp 1", m_wrap);
        end
        end_frame();
        cs_low();
        @(posedge clk);
        #1;
        end_frame();
        n_checks++;
        if (m_wrap !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_sticky got %b exp 1", m_wrap);
        end
    endtask

    task automatic test_abort();
        logic strobe_seen;
        sel = 1'b0;
        f_tx[0] = 8'h10;
        cs_low();
        run_bytes(0, 1);
        strobe_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mosi = ~i[0];
            @(negedge clk);
            if (m_wr || m_rd) strobe_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if ({strobe_seen, m_state, m_cnt} !== {1'b0, 2'b01, 8'd1}) begin
            n_errors++;
            $display("FAIL abort_partial got strobe=%b st=%b cnt=%0d exp 0/01/1", strobe_seen, m_state, m_cnt);
        end
        cs0_n = 1'b1;
        #1;
        n_checks++;
        if ({m_wr, m_state, m_cnt, m_addr} !== {1'b0, 2'b00, 8'd0, 7'h00}) begin
            n_errors++;
            $display("FAIL abort_clear got wr=%b st=%b cnt=%0d addr=%h exp 0/00/0/00", m_wr, m_state, m_cnt, m_addr);
        end
        @(posedge clk);
        #1;
        f_tx[0] = 8'h10; f_tx[1] = 8'h55;
        f_exp[0] = exp_byte(8'hA5, 1'b0, 1'b0, 7'h00, 8'h00);
        f_exp[1] = exp_byte(8'h00, 1'b1, 1'b0, 7'h10, 8'h55);
        cs_low();
        run_bytes(0, 2);
        for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (pack_obs(j) !== f_exp[j]) begin
                n_errors++;
                $display("FAIL abort_next byte%0d got %h exp %h (miso,wr,rd,addr,data,early)", j, pack_obs(j), f_exp[j]);
            end
        end
        end_frame();
    endtask

    task automatic test_reset_mid_frame();
        sel = 1'b0;
        n_checks++;
        if (m_wrap !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_pre_wrap got %b exp 1", m_wrap);
        end
        mem[1] = 8'h7E;
        f_tx[0] = 8'h81; f_tx[1] = 8'h00;
        cs_low();
        run_bytes(0, 2);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b0;
            @(posedge clk);
            #1;
        end
        rst_l = 1'b0;
        #1;
        n_checks++;
        if ({m_state, m_cnt, m_addr, m_wr, m_rd, m_wdata, m_wrap, m_miso} !== {2'b00, 8'h00, 7'h00, 2'b00, 8'h00, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL rst_mid got st=%b cnt=%h addr=%h wr=%b rd=%b wd=%h wrap=%b miso=%b exp 00/00/00/0/0/00/0/1",
                     m_state, m_cnt, m_addr, m_wr, m_rd, m_wdata, m_wrap, m_miso);
        end
        cs0_n = 1'b1;
        #1;
        rst_l = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_no_autoinc();
        sel = 1'b1;
        mem[5] = 8'h96; mem[6] = 8'hFF;
        f_tx[0] = 8'h85;
        for (int j = 1; j < 5; j++) f_tx[j] = 8'h00;
        f_exp[0] = exp_byte(8'hA5, 1'b0, 1'b0, 7'h00, 8'h00);
        f_exp[1] = exp_byte(8'h00, 1'b0, 1'b1, 7'h05, 8'h00);
        for (int j = 2; j < 5; j++) f_exp[j] = exp_byte(8'h96, 1'b0, 1'b1, 7'h05, 8'h00);
        cs_low();
        run_bytes(0, 5);
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (pack_obs(j) !== f_exp[j]) begin
                n_errors++;
                $display("FAIL noinc byte%0d got %h exp %h (miso,wr,rd,addr,data,early)", j, pack_obs(j), f_exp[j]);
            end
        end
        end_frame();
    endtask

    task automatic test_count_saturate();
        sel = 1'b1;
        f_tx[0] = 8'h7F;
        for (int j = 1; j < 257; j++) f_tx[j] = 8'(j);
        cs_low();
        run_bytes(0, 255);
        n_checks++;
        if (m_cnt !== 8'd255) begin
            n_errors++;
            $display("FAIL sat_reach got cnt=%0d exp 255", m_cnt);
        end
        run_bytes(255, 2);
        n_checks++;
        if (m_cnt !== 8'd255) begin
            n_errors++;
            $display("FAIL sat_hold got cnt=%0d exp 255", m_cnt);
        end
        n_checks++;
        if ({pack_obs(256), m_wrap, m_addr} !== {exp_byte(8'h00, 1'b1, 1'b0, 7'h7F, 8'h00), 1'b0, 7'h7F}) begin
            n_errors++;
            $display("FAIL sat_last got %h wrap=%b addr=%h exp %h wrap=0 addr=7f", pack_obs(256), m_wrap, m_addr,
                     exp_byte(8'h00, 1'b1, 1'b0, 7'h7F, 8'h00));
        end
        end_frame();
    endtask

    initial begin
        for (int a = 0; a < 128; a++) mem[a] = 8'h00;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_abort();
        test_reset_mid_frame();
        test_no_autoinc();
        test_count_saturate();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish within 500000 time units");
        $fatal(1);
    end

endmodule
